alu_req_serializer: RTL and testbench

// Host-side transmitter for the ALU serial request link. Accepts one request
// (command byte + up to MAX_OPS operand bytes) over a valid/ready handshake and

---
 rtl/alu_req_serializer.sv | 183 ++++++++++++++++++
 tb/tb_alu_req_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_serializer.sv
// alu_req_serializer
//   Host-side transmitter for the ALU serial request link. Latches one request
//   (command byte + up to MAX_OPS operand bytes) on a valid/ready handshake and
//   shifts it out on sout as 12-bit framed words: all operand words first, the
//   command word last.
//   Frame bits, in order: start(0), flag(1=cmd), payload[7:0] MSB first,
//   even parity over flag+payload (optionally inverted), stop(1).
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_cmd           command byte
//   req_nops          operand count, clamped to MAX_OPS
//   req_data          operand bytes, byte i at [8*i+:8], byte 0 sent first
//   req_inj_dpar      invert parity of the first operand word
//   req_inj_cpar      invert parity of the command word
//   sout              registered serial line, idle high
//   busy              request in flight (includes the done cycle)
//   done              one-cycle pulse after the last stop bit
module alu_req_serializer #(
   parameter int MAX_OPS      = 9,
   parameter int CLKS_PER_BIT = 1,
   parameter int GAP_CLKS     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [7:0]           req_cmd,
   input  logic [3:0]           req_nops,
   input  logic [8*MAX_OPS-1:0] req_data,
   input  logic                 req_inj_dpar,
   input  logic                 req_inj_cpar,
   output logic                 sout,
   output logic                 busy,
   output logic                 done
);

   localparam int NW = $clog2(MAX_OPS + 1);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [11:0]          sh_q, sh_d;       // current frame, bit 11 is on the line
   logic [3:0]           bit_q, bit_d;
   logic [CW-1:0]        cpb_q, cpb_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [NW-1:0]        wi_q, wi_d;       // word index; wi == nops is the command word
   logic [NW-1:0]        nops_q, nops_d;
   logic [7:0]           cmd_q, cmd_d;
   logic [8*MAX_OPS-1:0] data_q, data_d;
   logic                 dinj_q, dinj_d;
   logic                 cinj_q, cinj_d;
   logic                 sout_q, sout_d;
   logic [NW-1:0]        eff_nops;

   function automatic logic [11:0] mk_frame(input logic flag, input logic [7:0] pl,
                                            input logic inj);
      return {1'b0, flag, pl, (^{flag, pl}) ^ inj, 1'b1};
   endfunction

   function automatic logic [11:0] word_frame(input logic [NW-1:0] idx,
                                              input logic [NW-1:0] nops,
                                              input logic [7:0] cmd,
                                              input logic [8*MAX_OPS-1:0] data,
                                              input logic dinj, input logic cinj);
      if (idx < nops)
         return mk_frame(1'b0, data[8*int'(idx) +: 8], dinj && (idx == '0));
      return mk_frame(1'b1, cmd, cinj);
   endfunction

   always_comb begin
      if (int'(req_nops) > MAX_OPS) eff_nops = NW'(MAX_OPS);
      else                          eff_nops = NW'(req_nops);
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      cpb_d   = cpb_q;
      gap_d   = gap_q;
      wi_d    = wi_q;
      nops_d  = nops_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      dinj_d  = dinj_q;
      cinj_d  = cinj_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               nops_d  = eff_nops;
               cmd_d   = req_cmd;
               data_d  = req_data;
               dinj_d  = req_inj_dpar;
               cinj_d  = req_inj_cpar;
               wi_d    = '0;
               bit_d   = '0;
               cpb_d   = '0;
               sh_d    = word_frame('0, eff_nops, req_cmd, req_data,
                                    req_inj_dpar, req_inj_cpar);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (int'(cpb_q) == CLKS_PER_BIT - 1) begin
               cpb_d = '0;
               if (bit_q == 4'd11) begin
                  bit_d = '0;
                  if (wi_q == nops_q) begin
                     state_d = S_DONE;
                  end else begin
                     wi_d = wi_q + NW'(1);
                     if (GAP_CLKS == 0) begin
                        sh_d = word_frame(wi_q + NW'(1), nops_q, cmd_q, data_q,
                                          dinj_q, cinj_q);
                     end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                     end
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  sh_d  = {sh_q[10:0], 1'b1};
               end
            end else begin
               cpb_d = cpb_q + CW'(1);
            end
         end
         S_GAP: begin
            if (int'(gap_q) == GAP_CLKS - 1) begin
               sh_d    = word_frame(wi_q, nops_q, cmd_q, data_q, dinj_q, cinj_q);
               bit_d   = '0;
               cpb_d   = '0;
               state_d = S_SHIFT;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Line value for the next cycle follows the next state, keeping sout a flop.
      sout_d = (state_d == S_SHIFT) ? sh_d[11] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '1;
         bit_q   <= '0;
         cpb_q   <= '0;
         gap_q   <= '0;
         wi_q    <= '0;
         nops_q  <= '0;
         cmd_q   <= '0;
         data_q  <= '0;
         dinj_q  <= 1'b0;
         cinj_q  <= 1'b0;
         sout_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         cpb_q   <= cpb_d;
         gap_q   <= gap_d;
         wi_q    <= wi_d;
         nops_q  <= nops_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         dinj_q  <= dinj_d;
         cinj_q  <= cinj_d;
         sout_q  <= sout_d;
      end
   end

   assign sout      = sout_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign req_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_alu_req_serializer.sv
// Directed bench for alu_req_serializer. Instance a uses default parameters,
// instance b runs CLKS_PER_BIT=3, GAP_CLKS=0 for the slow back-to-back case.
module tb_alu_req_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_valid = 1'b0, a_ready, a_dinj = 1'b0, a_cinj = 1'b0;
   logic [7:0]  a_cmd = '0;
   logic [3:0]  a_nops = '0;
   logic [71:0] a_data = '0;
   logic        a_sout, a_busy, a_done;

   logic        b_valid = 1'b0, b_ready;
   logic [7:0]  b_cmd = '0;
   logic [3:0]  b_nops = '0;
   logic [71:0] b_data = '0;
   logic        b_sout, b_busy, b_done;

   int checks = 0;
   int failures = 0;

   alu_req_serializer u_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
      .req_cmd(a_cmd), .req_nops(a_nops), .req_data(a_data),
      .req_inj_dpar(a_dinj), .req_inj_cpar(a_cinj),
      .sout(a_sout), .busy(a_busy), .done(a_done));

   alu_req_serializer #(.MAX_OPS(9), .CLKS_PER_BIT(3), .GAP_CLKS(0)) u_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
      .req_cmd(b_cmd), .req_nops(b_nops), .req_data(b_data),
      .req_inj_dpar(1'b0), .req_inj_cpar(1'b0),
      .sout(b_sout), .busy(b_busy), .done(b_done));

   // Hand-computed frames: start, flag, payload, parity, stop.
   localparam logic [11:0] F_D12   = 12'b0_0_00010010_0_1;
   localparam logic [11:0] F_D34   = 12'b0_0_00110100_1_1;
   localparam logic [11:0] F_ADD   = 12'b0_1_00010000_0_1;
   localparam logic [11:0] F_XOR   = 12'b0_1_00000011_1_1;
   localparam logic [11:0] F_DFF_I = 12'b0_0_11111111_1_1;
   localparam logic [11:0] F_AND_I = 12'b0_1_00000001_1_1;

   // Launch one request on instance a; the caller then sits in cycle 0
   // (first start bit). Inputs are scrambled afterwards to prove latching.
   task automatic xfer_a(input logic [7:0] cmd, input logic [3:0] nops,
                         input logic [71:0] data, input logic dinj, input logic cinj);
      @(posedge clk); #1;
      a_cmd = cmd; a_nops = nops; a_data = data; a_dinj = dinj; a_cinj = cinj;
      a_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_cmd = 8'hEE; a_nops = 4'd7; a_data = {9{8'hA5}}; a_dinj = ~dinj; a_cinj = ~cinj;
   endtask

   // Sample n cycles of sout (first sample lands in bits[n-1]) and the first done.
   task automatic cap_a(input int n, output logic [255:0] bits, output int done_at);
      bits = '1;
      done_at = -1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bits[n-1-k] = a_sout;
         if (a_done && done_at < 0) done_at = k;
      end
   endtask

   task automatic test_reset;
      checks += 4;
      if (a_sout !== 1'b1)  begin failures++; $display("FAIL reset_sout got=%b exp=1", a_sout); end
      if (a_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
      if (a_done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
   endtask

   task automatic test_cmd_add;
      logic [255:0] got; int dat; logic bsy, rdy;
      xfer_a(8'h10, 4'd2, 72'h3412, 1'b0, 1'b0);
      @(negedge clk); bsy = a_busy; rdy = a_ready;
      checks += 2;
      if (bsy !== 1'b1) begin failures++; $display("FAIL add_busy_rise got=%b exp=1", bsy); end
      if (rdy !== 1'b0) begin failures++; $display("FAIL add_ready_low got=%b exp=0", rdy); end
      // One sample consumed above; capture the remaining 38 (k=1..38).
      cap_a(38, got, dat);
      checks += 2;
      if ({a_sout_first_dummy(bsy), got[37:0]} !== {1'b1, F_D12[10:0], 1'b1, F_D34, 1'b1, F_ADD, 1'b1})
      begin
         failures++;
         $display("FAIL add_stream got=%b exp=%b", got[37:0], {F_D12[10:0], 1'b1, F_D34, 1'b1, F_ADD, 1'b1});
      end
      if (dat !== 37) begin failures++; $display("FAIL add_done_at got=%0d exp=38", dat + 1); end
   endtask

   // Echoes its argument so the concatenation above keeps the first-cycle
   // busy value in the comparison width.
   function automatic logic a_sout_first_dummy(input logic v);
      return v;
   endfunction

   task automatic test_nops_zero;
      logic [255:0] got; int dat;
      xfer_a(8'h03, 4'd0, 72'hFF, 1'b1, 1'b0);   // dinj must be ignored
      cap_a(13, got, dat);
      checks += 2;
      if (got[12:0] !== {F_XOR, 1'b1}) begin
         failures++; $display("FAIL xor_stream got=%b exp=%b", got[12:0], {F_XOR, 1'b1});
      end
      if (dat !== 12) begin failures++; $display("FAIL xor_done_at got=%0d exp=12", dat); end
   endtask

   task automatic test_parity_inject;
      logic [255:0] got; int dat;
      xfer_a(8'h01, 4'd1, 72'hFF, 1'b1, 1'b1);
      cap_a(26, got, dat);
      checks += 2;
      if (got[25:0] !== {F_DFF_I, 1'b1, F_AND_I, 1'b1}) begin
         failures++; $display("FAIL inj_stream got=%b exp=%b", got[25:0], {F_DFF_I, 1'b1, F_AND_I, 1'b1});
      end
      if (dat !== 25) begin failures++; $display("FAIL inj_done_at got=%0d exp=25", dat); end
   endtask

   task automatic test_clamp;
      logic [255:0] got; int dat;
      // 10 words: 10*12 + 9 gaps = 129 cycles to done.
      xfer_a(8'h10, 4'd15, {9{8'h12}}, 1'b0, 1'b0);
      cap_a(130, got, dat);
      checks += 3;
      if (dat !== 129) begin failures++; $display("FAIL clamp_done_at got=%0d exp=129", dat); end
      if (got[129:118] !== F_D12) begin
         failures++; $display("FAIL clamp_first_word got=%b exp=%b", got[129:118], F_D12);
      end
      if (got[12:1] !== F_ADD) begin
         failures++; $display("FAIL clamp_cmd_word got=%b exp=%b", got[12:1], F_ADD);
      end
   endtask

   task automatic test_reset_mid;
      int ndone = 0;
      xfer_a(8'h10, 4'd2, 72'h3412, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks += 4;
      if (a_sout !== 1'b1)  begin failures++; $display("FAIL mid_rst_sout got=%b exp=1", a_sout); end
      if (a_busy !== 1'b0)  begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", a_busy); end
      if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", a_ready); end
      if (a_done !== 1'b0)  begin failures++; $display("FAIL mid_rst_done got=%b exp=0", a_done); end
      reset = 1'b0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (a_done || a_sout !== 1'b1) ndone++;
      end
      checks++;
      if (ndone !== 0) begin failures++; $display("FAIL mid_rst_quiet got=%0d exp=0 active cycles", ndone); end
   endtask

   task automatic test_slow_back_to_back;
      logic [23:0] w2;
      logic [71:0] got, exp;
      int dat = -1, ndone = 0;
      logic rdy73, s74, b74, rb, rs;
      w2 = {F_D12, F_XOR};
      for (int k = 0; k < 72; k++) exp[71-k] = w2[23 - k/3];
      @(posedge clk); #1;
      b_cmd = 8'h03; b_nops = 4'd1; b_data = 72'h12; b_valid = 1'b1;  // held high
      @(posedge clk); #1;
      for (int k = 0; k < 75; k++) begin
         @(negedge clk);
         if (k < 72) got[71-k] = b_sout;
         if (b_done && dat < 0) dat = k;
         if (k == 73) rdy73 = b_ready;
         if (k == 74) begin s74 = b_sout; b74 = b_busy; end
      end
      checks += 5;
      if (got !== exp) begin failures++; $display("FAIL b2b_stream got=%h exp=%h", got, exp); end
      if (dat !== 72) begin failures++; $display("FAIL b2b_done_at got=%0d exp=72", dat); end
      if (rdy73 !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", rdy73); end
      if (s74 !== 1'b0) begin failures++; $display("FAIL b2b_second_start got=%b exp=0", s74); end
      if (b74 !== 1'b1) begin failures++; $display("FAIL b2b_second_busy got=%b exp=1", b74); end
      // Abort the second request partway through its first word.
      repeat (10) @(negedge clk);
      reset = 1'b1; b_valid = 1'b0;
      @(posedge clk); #1;
      rb = b_busy; rs = b_sout;
      reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (b_done) ndone++;
      end
      checks += 3;
      if (rb !== 1'b0) begin failures++; $display("FAIL b2b_rst_busy got=%b exp=0", rb); end
      if (rs !== 1'b1) begin failures++; $display("FAIL b2b_rst_sout got=%b exp=1", rs); end
      if (ndone !== 0) begin failures++; $display("FAIL b2b_rst_no_done got=%0d exp=0", ndone); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      reset = 1'b0;
      test_cmd_add;
      test_nops_zero;
      test_parity_inject;
      test_clamp;
      test_reset_mid;
      test_slow_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
